axis_header_insert: RTL
=======================

// Module: axis_header_insert
// PURPOSE
//  Consumes a header beat from the insert-header master and an AXI-Stream data packet.
//  Emits one packet made of the header's valid bytes followed immediately by all data bytes,
//  re-packed to full-width beats. Sits directly downstream of the header source and the data source.
//  Byte order is big-endian: byte lane DATA_BYTE_WD-1 (MSB) is first on the wire.
// PARAMETERS
//  DATA_WD       32               stream data width in bits, multiple of 8
//  DATA_BYTE_WD  DATA_WD/8        bytes per beat (N)
//  BYTE_CNT_WD   $clog2(N)        header byte count width is BYTE_CNT_WD+1
// PORTS
//  clk             in   1                clock
//  rst_n           in   1                reset, asynchronous, active-low
//  valid_in        in   1                data beat valid
//  data_in         in   DATA_WD          data beat
//  keep_in         in   N                byte enables: all ones, except last beat left-aligned (e.g. 1100)
//  last_in         in   1                last beat of packet
//  ready_in        out  1                data beat accepted when valid_in&&ready_in
//  valid_insert    in   1                header beat valid
//  data_insert     in   DATA_WD          header; valid bytes right-aligned in the low lanes
//  keep_insert     in   N                header byte enables, right-aligned (e.g. 0111)
//  byte_insert_cnt in   BYTE_CNT_WD+1    number of header bytes, 0..N
//  ready_insert    out  1                header accepted when valid_insert&&ready_insert
//  valid_out       out  1                output beat valid
//  data_out        out  DATA_WD          output beat; lanes not enabled are driven 0
//  keep_out        out  N                all ones, except last beat left-aligned
//  last_out        out  1                last beat of output packet
//  ready_out       in   1                downstream ready
// BEHAVIOUR
//  Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0, state=S_HDR, carry=0, ccnt=0.
//  Output register: loads when adv = !valid_out || ready_out. It holds data/keep/last stable
//   while valid_out && !ready_out. Latency is 1 cycle from accepted input to valid_out.
//   Full throughput (one beat per cycle) when ready_out=1.
//  Header beat:
//   - byte_insert_cnt is authoritative. Values > N clamp to N. keep_insert is checked by assertion only.
//   - The bench checks keep_insert == (1<<cnt)-1.
//  State machine:
//   S_HDR : ready_insert=1, ready_in=0.
//           On header handshake: carry <= low cnt bytes of data_insert, ccnt <= cnt, go to S_DATA.
//   S_DATA: ready_insert=0, ready_in=adv. Per accepted beat with k valid bytes (k=N unless last):
//           - output = carry bytes (ccnt) followed by the first N-ccnt bytes of data_in;
//             carry <= the remaining ccnt bytes.
//           - last_in with ccnt+k <= N: emit ccnt+k bytes, last_out=1, ccnt<=0, go to S_HDR.
//           - last_in with ccnt+k > N: emit N bytes with last_out=0, ccnt <= ccnt+k-N, go to S_TAIL.
//   S_TAIL: ready_in=0, ready_insert=0. On adv: emit the carry left-aligned (ccnt bytes),
//           last_out=1, then go to S_HDR.
//  Special cases:
//   - ccnt=0 (header count 0): the data packet passes through unmodified.
//   - ccnt=N: output lags input by one full beat.
//  Output stall: valid_out && !ready_out deasserts ready_in and leaves state/carry unchanged.
//   S_HDR still accepts the next header while the previous last beat waits in the output register.
//  valid_in in S_HDR is not accepted: ready_in=0 until the header arrives.
//  No data is dropped. Exactly one header is consumed per packet.
//  Reset mid-packet: all state clears asynchronously and the partial packet is discarded.
//   The first header after reset starts a clean packet.
// TESTING  (N=4)
//  1 hdr cnt=3 0x00AABBCC; data 0x11223344(1111), 0x55667788 last keep=1100 ->
//    0xAABBCC11/1111, 0x22334455/1111, 0x66000000/1000 last.
//  2 hdr cnt=1 0x000000EE; data 0x12345678 last keep=1110 -> single beat 0xEE123456/1111 last=1.
//  3 hdr cnt=4 0xDEADBEEF; data 0x01020304 last/1111 -> 0xDEADBEEF/1111 last=0, 0x01020304/1111 last=1.
//  4 valid_in held before any header -> ready_in=0, valid_out=0 until the header handshake,
//    then data flows.
//  5 random valid_in/valid_insert/ready_out, 1000 packets, cnt 0..4 -> output matches the byte-queue
//    model; no change to outputs while stalled.
//  6 rst_n low in S_DATA mid-packet -> valid_out=0 and ready_insert=1 immediately;
//    the next packet (case 1) is output correctly.

Source files
------------

// File: rtl/axis_header_insert_if.sv
// Bus bundle for the header-insert block: the data stream in, the header beat in,
// and the re-packed stream out.
//
// Handshake rule for every channel here: a beat transfers on the rising clk edge
// where valid and ready are both 1. The source holds valid and its payload stable
// until that transfer. valid never waits on ready, and ready may depend on valid.
interface axis_header_insert_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    // data packet from the data source
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;

    // header beat from the insert-header master
    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD:0]    byte_insert_cnt;
    logic                    ready_insert;

    // re-packed output packet
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    modport master (
        output valid_in, data_in, keep_in, last_in,
        input  ready_in,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_insert,
        input  valid_out, data_out, keep_out, last_out,
        output ready_out
    );

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        output ready_in,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_insert,
        output valid_out, data_out, keep_out, last_out,
        input  ready_out
    );
endinterface

// File: rtl/axis_header_insert.sv
// Prepends the valid bytes of one header beat to an AXI-Stream packet and re-packs
// the result into full-width beats. Byte lane N-1 is first on the wire.
// The header bytes are held as a "carry". Each data beat emits the carry followed
// by the leading data bytes, and the trailing data bytes become the next carry.
module axis_header_insert #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axis_header_insert_if.slave  bus,
    output logic [1:0]           state_dbg
);
    localparam int N  = DATA_BYTE_WD;
    localparam int CW = BYTE_CNT_WD + 1;   // byte counts 0..N
    localparam int SW = CW + 1;            // carry + beat byte sums 0..2N

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_WD-1:0] carry_q, carry_d;
    logic [CW-1:0]      ccnt_q, ccnt_d;

    logic               valid_out_q;
    logic [DATA_WD-1:0] data_out_q;
    logic [N-1:0]       keep_out_q;
    logic               last_out_q;

    logic               load_out;
    logic [DATA_WD-1:0] nxt_data;
    logic [N-1:0]       nxt_keep;
    logic               nxt_last;

    logic               adv, hdr_fire, data_fire, tail_fire;
    logic [CW-1:0]      hdr_cnt, beat_cnt, free_lanes;
    logic [SW-1:0]      total;
    logic [DATA_WD-1:0] packed_beat, tail_carry;
    logic [N-1:0]       hdr_keep_exp;

    // Left-aligned byte enables for m bytes (m may exceed N; then all lanes).
    function automatic logic [N-1:0] left_keep(input logic [SW-1:0] m);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ((i + int'(m)) >= N);
        return r;
    endfunction

    // Expand byte enables to a bit mask so disabled lanes are driven 0.
    function automatic logic [DATA_WD-1:0] lane_mask(input logic [N-1:0] k);
        logic [DATA_WD-1:0] r;
        for (int i = 0; i < N; i++) r[i*8 +: 8] = {8{k[i]}};
        return r;
    endfunction

    // The output register may take a new beat when empty or being drained.
    assign adv       = !valid_out_q || bus.ready_out;
    assign hdr_fire  = (state_q == S_HDR)  && bus.valid_insert;
    assign data_fire = (state_q == S_DATA) && adv && bus.valid_in;
    assign tail_fire = (state_q == S_TAIL) && adv;

    // The byte count is authoritative; anything above N means a full header beat.
    assign hdr_cnt = (bus.byte_insert_cnt > CW'(N)) ? CW'(N) : bus.byte_insert_cnt;

    // Count the bytes carried by the current data beat (only a last beat is partial).
    always_comb begin
        beat_cnt = CW'(N);
        if (bus.last_in) begin
            beat_cnt = '0;
            for (int i = 0; i < N; i++) beat_cnt = beat_cnt + CW'(bus.keep_in[i]);
        end
    end

    assign total       = SW'(ccnt_q) + SW'(beat_cnt);
    assign free_lanes  = CW'(N) - ccnt_q;
    // Carry sits in the low ccnt lanes just above data_in, so one shift aligns the stream.
    assign packed_beat = DATA_WD'({carry_q, bus.data_in} >> {ccnt_q, 3'b000});
    // Leftover bytes of an overflowing last beat, moved up to lane N-1 for the tail beat.
    assign tail_carry  = bus.data_in << {free_lanes, 3'b000};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_HDR;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR:   if (hdr_fire) state_d = S_DATA;
            S_DATA:  if (data_fire && bus.last_in)
                         state_d = (total <= SW'(N)) ? S_HDR : S_TAIL;
            S_TAIL:  if (tail_fire) state_d = S_HDR;
            default: state_d = S_HDR;
        endcase
    end

    // FSM outputs: handshake readies, the next output beat and the next carry.
    always_comb begin
        bus.ready_insert = 1'b0;
        bus.ready_in     = 1'b0;
        load_out         = 1'b0;
        nxt_data         = '0;
        nxt_keep         = '0;
        nxt_last         = 1'b0;
        carry_d          = carry_q;
        ccnt_d           = ccnt_q;
        case (state_q)
            S_HDR: begin
                bus.ready_insert = 1'b1;
                if (hdr_fire) begin
                    carry_d = bus.data_insert;
                    ccnt_d  = hdr_cnt;
                end
            end
            S_DATA: begin
                bus.ready_in = adv;
                if (data_fire) begin
                    load_out = 1'b1;
                    carry_d  = bus.data_in;
                    if (bus.last_in && (total <= SW'(N))) begin
                        nxt_keep = left_keep(total);
                        nxt_last = 1'b1;
                        ccnt_d   = '0;
                    end else begin
                        nxt_keep = '1;
                        if (bus.last_in) begin
                            ccnt_d  = CW'(total - SW'(N));
                            carry_d = tail_carry;
                        end
                    end
                    nxt_data = packed_beat & lane_mask(nxt_keep);
                end
            end
            S_TAIL: begin
                if (tail_fire) begin
                    load_out = 1'b1;
                    nxt_keep = left_keep(SW'(ccnt_q));
                    nxt_last = 1'b1;
                    nxt_data = carry_q & lane_mask(nxt_keep);
                    ccnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // Carry bytes and their count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= '0;
            ccnt_q  <= '0;
        end else begin
            carry_q <= carry_d;
            ccnt_q  <= ccnt_d;
        end
    end

    // Output register: loads on adv, holds its payload while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
        end else if (adv) begin
            valid_out_q <= load_out;
            if (load_out) begin
                data_out_q <= nxt_data;
                keep_out_q <= nxt_keep;
                last_out_q <= nxt_last;
            end
        end
    end

    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.keep_out  = keep_out_q;
    assign bus.last_out  = last_out_q;
    assign state_dbg     = state_q;

    // Header byte enables implied by the clamped byte count.
    always_comb begin
        for (int i = 0; i < N; i++) hdr_keep_exp[i] = (i < int'(hdr_cnt));
    end

    a_hdr_keep: assert property (@(posedge clk) disable iff (!rst_n)
        hdr_fire |-> (bus.keep_insert == hdr_keep_exp));

endmodule
